rv_instr_encoder: RTL and testbench

//  Instruction-side counterpart of the control decoder: accepts symbolic ops (kind, ALU op, regs, imm)

---
 rtl/rv_pkg.sv | 48 ++++
 rtl/rv_instr_pack.sv | 60 ++++++
 rtl/rv_instr_encoder.sv | 146 ++++++++++++++
 tb/tb_rv_instr_encoder.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I encoding constants: opcodes, func3/func7 fields, ALU control and op-kind codes.
package rv_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned IMM_W  = 13;
  localparam int unsigned KIND_W = 3;
  localparam int unsigned ALU_W  = 3;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_B  = 7'b1100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_WORD    = 3'b010;
  localparam logic [2:0] F3_BEQ     = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  // ALU control codes shared with the ALU decoder
  localparam logic [ALU_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALU_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALU_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALU_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALU_W-1:0] ALU_SLT = 3'b101;

  localparam logic [KIND_W-1:0] KIND_R   = 3'b000;
  localparam logic [KIND_W-1:0] KIND_I   = 3'b001;
  localparam logic [KIND_W-1:0] KIND_LW  = 3'b010;
  localparam logic [KIND_W-1:0] KIND_SW  = 3'b011;
  localparam logic [KIND_W-1:0] KIND_BEQ = 3'b100;

  localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_WRITE  = 2'd2,
    ST_DONE   = 2'd3
  } enc_state_e;

endpackage

// File: rtl/rv_instr_pack.sv
// Combinational field packer: symbolic op -> RV32I word, with illegal-op detection.
module rv_instr_pack
  import rv_pkg::*;
(
  input  logic [KIND_W-1:0] op_kind,
  input  logic [ALU_W-1:0]  alu_sel,
  input  logic [REG_W-1:0]  rd,
  input  logic [REG_W-1:0]  rs1,
  input  logic [REG_W-1:0]  rs2,
  input  logic [IMM_W-1:0]  imm,
  output logic [XLEN-1:0]   word,
  output logic              illegal
);

  logic [2:0] f3;
  logic [6:0] f7;
  logic       alu_ok;

  // ALU op -> func3/func7 for the register and immediate forms
  always_comb begin
    f3     = F3_ADD_SUB;
    f7     = F7_BASE;
    alu_ok = 1'b1;
    case (alu_sel)
      ALU_ADD: f3 = F3_ADD_SUB;
      ALU_SUB: begin
        f3 = F3_ADD_SUB;
        f7 = F7_SUB;
      end
      ALU_AND: f3 = F3_AND;
      ALU_OR:  f3 = F3_OR;
      ALU_SLT: f3 = F3_SLT;
      default: alu_ok = 1'b0;
    endcase
  end

  // Illegal ops fall through to the NOP default
  always_comb begin
    word    = NOP_WORD;
    illegal = 1'b0;
    case (op_kind)
      KIND_R: begin
        if (alu_ok) word = {f7, rs2, rs1, f3, rd, OP_R};
        else        illegal = 1'b1;
      end
      KIND_I: begin
        if (alu_ok && (alu_sel != ALU_SUB)) word = {imm[11:0], rs1, f3, rd, OP_I};
        else                                illegal = 1'b1;
      end
      KIND_LW: word = {imm[11:0], rs1, F3_WORD, rd, OP_LW};
      KIND_SW: word = {imm[11:5], rs2, rs1, F3_WORD, imm[4:0], OP_SW};
      KIND_BEQ: begin
        if (!imm[0]) word = {imm[12], imm[10:5], rs2, rs1, F3_BEQ, imm[4:1], imm[11], OP_B};
        else         illegal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv_instr_encoder.sv
// Program loader: accepts symbolic ops over valid/ready, encodes them and writes
// them sequentially into instruction memory, one word every two cycles.
module rv_instr_encoder
  import rv_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned DEPTH     = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_last,
  input  logic [2:0]        op_kind,
  input  logic [2:0]        alu_sel,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [12:0]       imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              ovf
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  enc_state_e       state_q;
  enc_state_e       state_nx;
  logic [XLEN-1:0]  pack_word;
  logic             pack_illegal;
  logic             last_q;
  logic             accept;
  logic             in_write;
  logic             full_nx;
  logic [CNT_W-1:0] count_inc;
  logic             ready_d;
  logic             we_d;
  logic             busy_d;
  logic             done_d;

  rv_instr_pack u_pack (
    .op_kind (op_kind),
    .alu_sel (alu_sel),
    .rd      (rd),
    .rs1     (rs1),
    .rs2     (rs2),
    .imm     (imm),
    .word    (pack_word),
    .illegal (pack_illegal)
  );

  assign in_write  = (state_q == ST_WRITE);
  assign accept    = (state_q == ST_ACCEPT) && req_valid && !start;
  assign count_inc = count + CNT_W'(1);
  assign full_nx   = (count_inc == CNT_W'(DEPTH));

  // State register; handshake/status outputs are registered alongside it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      req_ready <= 1'b0;
      imem_we   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_nx;
      req_ready <= ready_d;
      imem_we   <= we_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  // Next state; start wins over everything and drops an op accepted that cycle
  always_comb begin
    state_nx = state_q;
    if (start) begin
      state_nx = ST_ACCEPT;
    end else begin
      case (state_q)
        ST_IDLE:   state_nx = ST_IDLE;
        ST_ACCEPT: if (req_valid) state_nx = ST_WRITE;
        ST_WRITE:  state_nx = (last_q || full_nx) ? ST_DONE : ST_ACCEPT;
        ST_DONE:   state_nx = ST_DONE;
        default:   state_nx = ST_IDLE;
      endcase
    end
  end

  // Outputs decoded from the next state so they land in step with it
  always_comb begin
    ready_d = 1'b0;
    we_d    = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_nx)
      ST_ACCEPT: begin
        ready_d = 1'b1;
        busy_d  = 1'b1;
      end
      ST_WRITE: begin
        we_d   = 1'b1;
        busy_d = 1'b1;
      end
      ST_DONE: done_d = 1'b1;
      default: ;
    endcase
  end

  // Encoded word, address/count counters and sticky flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imem_addr  <= ADDR_W'(BASE_ADDR);
      imem_wdata <= '0;
      count      <= '0;
      err        <= 1'b0;
      ovf        <= 1'b0;
      last_q     <= 1'b0;
    end else if (start) begin
      imem_addr <= ADDR_W'(BASE_ADDR);
      count     <= '0;
      err       <= 1'b0;
      ovf       <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      if (accept) begin
        imem_wdata <= pack_word;
        last_q     <= req_last;
        err        <= err | pack_illegal;
      end
      if (in_write) begin
        imem_addr <= imem_addr + ADDR_W'(1);
        count     <= count_inc;
        if (full_nx) ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rv_instr_encoder.sv
// Scoreboard bench for rv_instr_encoder: directed programs, full/restart/reset cases and random programs.
module tb_rv_instr_encoder;

  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned BASE_ADDR = 5;
  localparam int unsigned DEPTH     = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_last = 1'b0;
  logic [2:0]        op_kind = '0;
  logic [2:0]        alu_sel = '0;
  logic [4:0]        rd = '0;
  logic [4:0]        rs1 = '0;
  logic [4:0]        rs2 = '0;
  logic [12:0]       imm = '0;
  logic              req_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   count;
  logic              busy;
  logic              done;
  logic              err;
  logic              ovf;

  rv_instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .req_valid(req_valid), .req_ready(req_ready),
    .req_last(req_last), .op_kind(op_kind), .alu_sel(alu_sel), .rd(rd), .rs1(rs1),
    .rs2(rs2), .imm(imm), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .count(count), .busy(busy), .done(done), .err(err), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t sb_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  mcount = 0;
  bit  merr = 0, movf = 0, mdone = 0, mbusy = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoding built from field positions with integer arithmetic
  function automatic logic [31:0] ref_encode(input logic [2:0] k, input logic [2:0] a,
                                             input logic [4:0] d, input logic [4:0] s1,
                                             input logic [4:0] s2, input logic [12:0] im,
                                             output bit bad);
    int unsigned u, f3, f7, w;
    bit alu_ok;
    u = 32'(im);
    alu_ok = 1; f3 = 0; f7 = 0;
    case (int'(a))
      0: f3 = 0;
      1: begin f3 = 0; f7 = 32; end
      2: f3 = 7;
      3: f3 = 6;
      5: f3 = 2;
      default: alu_ok = 0;
    endcase
    bad = 0; w = 0;
    case (int'(k))
      0: if (alu_ok) w = 'h33 + 32'(d) * 128 + f3 * 4096 + 32'(s1) * 32768 + 32'(s2) * (1 << 20) + f7 * (1 << 25);
         else bad = 1;
      1: if (alu_ok && a != 3'd1) w = 'h13 + 32'(d) * 128 + f3 * 4096 + 32'(s1) * 32768 + (u % 4096) * (1 << 20);
         else bad = 1;
      2: w = 'h03 + 32'(d) * 128 + 2 * 4096 + 32'(s1) * 32768 + (u % 4096) * (1 << 20);
      3: w = 'h23 + (u % 32) * 128 + 2 * 4096 + 32'(s1) * 32768 + 32'(s2) * (1 << 20) + ((u / 32) % 128) * (1 << 25);
      4: if (u % 2 == 0)
           w = 'h63 + ((u / 2048) % 2) * 128 + ((u / 2) % 16) * 256 + 32'(s1) * 32768 + 32'(s2) * (1 << 20)
               + ((u / 32) % 64) * (1 << 25) + ((u / 4096) % 2) * (1 << 31);
         else bad = 1;
      default: bad = 1;
    endcase
    if (bad) w = 'h13;
    return w;
  endfunction

  task automatic model_accept(input logic last, input logic [31:0] w, input bit bad);
    wr_t e;
    e.addr = ADDR_W'(BASE_ADDR + mcount);
    e.data = w;
    sb_q.push_back(e);
    if (bad) merr = 1;
    mcount++;
    if (mcount == DEPTH) begin movf = 1; mdone = 1; end
    if (last) mdone = 1;
    if (mdone) mbusy = 0;
  endtask

  task automatic set_op(input int k, input int a, input int d, input int s1, input int s2, input int im);
    op_kind = 3'(k); alu_sel = 3'(a); rd = 5'(d); rs1 = 5'(s1); rs2 = 5'(s2); imm = 13'(im);
  endtask

  // Called at a negedge; returns at the negedge right after the accepting edge
  task automatic send(input logic last, input logic [31:0] w, input bit bad);
    int waitc = 0;
    req_valid = 1'b1;
    req_last  = last;
    while (!req_ready && waitc <= 50) begin
      @(negedge clk);
      waitc++;
    end
    if (!req_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: req_ready never rose at %0t", $time);
      req_valid = 1'b0;
      return;
    end
    model_accept(last, w, bad);
    @(negedge clk);
    req_valid = 1'b0;
    req_last  = 1'b0;
  endtask

  task automatic send_model(input logic last);
    bit bad;
    logic [31:0] w;
    w = ref_encode(op_kind, alu_sel, rd, rs1, rs2, imm, bad);
    send(last, w, bad);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mcount = 0; merr = 0; movf = 0; mdone = 0; mbusy = 1;
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_count"}, 32'(count), 32'(mcount));
    chk({tag, "_done"},  32'(done),  32'(mdone));
    chk({tag, "_busy"},  32'(busy),  32'(mbusy));
    chk({tag, "_err"},   32'(err),   32'(merr));
    chk({tag, "_ovf"},   32'(ovf),   32'(movf));
    chk({tag, "_ready"}, 32'(req_ready), 32'(mbusy && !mdone));
    chk({tag, "_pending"}, 32'(sb_q.size()), 32'd0);
  endtask

  task automatic rand_fields();
    int k;
    k = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 4) : $urandom_range(5, 7);
    set_op(k, $urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 31),
           $urandom_range(0, 31), $urandom_range(0, 8191));
    if (k == 4 && $urandom_range(0, 3) != 0) imm[0] = 1'b0;
  endtask

  // Monitor: every write strobe pops one expected word; back-to-back strobes are an error
  initial begin
    logic prev_we;
    wr_t  e;
    prev_we = 1'b0;
    forever begin
      @(negedge clk);
      if (imem_we === 1'b1) begin
        chk("we_spacing", 32'(prev_we), 32'd0);
        if (sb_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%08h at %0t", imem_addr, imem_wdata, $time);
        end else begin
          e = sb_q.pop_front();
          chk("imem_addr", 32'(imem_addr), 32'(e.addr));
          chk("imem_wdata", imem_wdata, e.data);
        end
      end
      prev_we = imem_we;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1);
  end

  initial begin
    #1 rst = 1'b1;
    #2;
    chk("rst_we", 32'(imem_we), 0);
    chk("rst_addr", 32'(imem_addr), BASE_ADDR);
    chk("rst_wdata", imem_wdata, 0);
    chk("rst_ready", 32'(req_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_status("idle");

    // add x3,x1,x2 as the whole program
    pulse_start();
    check_status("start1");
    set_op(0, 0, 3, 1, 2, 0);
    send(1'b1, 32'h002081B3, 0);
    @(negedge clk);
    check_status("prog1");

    // sub / lw / sw / beq
    pulse_start();
    set_op(0, 1, 3, 1, 2, 0);   send(1'b0, 32'h402081B3, 0);
    set_op(2, 0, 5, 2, 0, 8);   send(1'b0, 32'h00812283, 0);
    set_op(3, 0, 0, 2, 5, 12);  send(1'b0, 32'h00512623, 0);
    set_op(4, 0, 0, 1, 2, -4);  send(1'b1, 32'hFE208EE3, 0);
    @(negedge clk);
    check_status("prog2");

    // illegal kind, then I-type sub
    pulse_start();
    set_op(7, 0, 3, 1, 2, 0);   send(1'b0, 32'h00000013, 1);
    set_op(1, 1, 4, 1, 0, 5);   send(1'b1, 32'h00000013, 1);
    @(negedge clk);
    check_status("prog3");
    set_op(4, 0, 0, 1, 2, 3);
    pulse_start();
    send_model(1'b1);
    @(negedge clk);
    check_status("beq_odd");

    // hold valid with a stream of ops until the program fills
    pulse_start();
    req_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (mdone) chk("ready_after_full", 32'(req_ready), 0);
      else if (req_ready) begin
        bit bad;
        logic [31:0] w;
        w = ref_encode(op_kind, alu_sel, rd, rs1, rs2, imm, bad);
        model_accept(1'b0, w, bad);
      end
      @(negedge clk);
      rand_fields();
    end
    req_valid = 1'b0;
    check_status("full");

    // restart in the middle of a program
    pulse_start();
    set_op(6, 0, 1, 1, 1, 0);   send_model(1'b0);
    set_op(0, 2, 7, 8, 9, 0);   send_model(1'b0);
    @(negedge clk);
    pulse_start();
    check_status("restart");
    set_op(0, 3, 10, 11, 12, 0);
    send_model(1'b1);
    @(negedge clk);
    check_status("after_restart");

    // reset in the WRITE cycle
    pulse_start();
    set_op(2, 0, 6, 3, 0, 100);
    send_model(1'b0);
    #2 rst = 1'b1;
    #1;
    chk("wrst_we", 32'(imem_we), 0);
    chk("wrst_addr", 32'(imem_addr), BASE_ADDR);
    chk("wrst_count", 32'(count), 0);
    chk("wrst_flags", {28'd0, busy, done, err, ovf}, 0);
    sb_q.delete();
    mcount = 0; merr = 0; movf = 0; mdone = 0; mbusy = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_status("wrst_idle");

    // random programs with random idle gaps and garbage fields
    for (int p = 0; p < 12; p++) begin
      int n;
      pulse_start();
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        int gap;
        gap = $urandom_range(0, 3);
        for (int g = 0; g < gap; g++) begin
          rand_fields();
          req_last = 1'($urandom_range(0, 1));
          @(negedge clk);
        end
        rand_fields();
        send_model((i == n - 1) && (n < 4 || $urandom_range(0, 1) == 1));
      end
      @(negedge clk);
      check_status("rand");
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
